ssp_tx_serializer: RTL

Transmit serializer of the synchronous serial port, sitting directly downstream of the transmit FIFO. When the FIFO is non-empty, it pops one byte by pulsing `t_en` and captures `txdata`. It then shifts the byte out MSB-first on `ssptxd` in a TI-style synchronous serial frame: a one-bit `sspfssout` pulse followed by 8 data bits. It also generates the serial clock `sspclkout` from `pclk`.

---
 rtl/ssp_tx_serializer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ssp_tx_serializer.sv
// SSP transmit serializer: pops the TX FIFO and shifts each word out MSB-first
// in a TI-style frame (one-bit sync pulse, then DATA_W data bits).
module ssp_tx_serializer #(
    parameter int DATA_W      = 8,
    parameter int HALF_PERIOD = 1
) (
    input  logic              pclk,
    input  logic              clear,
    input  logic              sse,
    input  logic              tx_empty,
    input  logic [DATA_W-1:0] txdata,
    output logic              t_en,
    output logic              ssptxd,
    output logic              sspclkout,
    output logic              sspfssout,
    output logic              sspoe_b,
    output logic              tx_busy
);

    localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        FSS,
        SHIFT
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               sclk_d;
    logic [DATA_W-1:0]  shreg, shreg_d;
    logic [BIT_W-1:0]   bitcnt, bitcnt_d;
    logic               txd_d, fss_d, oe_b_d, t_en_d;
    logic               wrap, rise_tick;

    always_ff @(posedge pclk) begin
        if (clear) begin
            state     <= IDLE;
            cnt       <= '0;
            sspclkout <= 1'b0;
            shreg     <= '0;
            bitcnt    <= '0;
            ssptxd    <= 1'b0;
            sspfssout <= 1'b0;
            sspoe_b   <= 1'b1;
            t_en      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            sspclkout <= sclk_d;
            shreg     <= shreg_d;
            bitcnt    <= bitcnt_d;
            ssptxd    <= txd_d;
            sspfssout <= fss_d;
            sspoe_b   <= oe_b_d;
            t_en      <= t_en_d;
        end
    end

    // Serial outputs only move on a rise tick, so they change with sspclkout rising.
    always_comb begin
        wrap      = (cnt == CNT_W'(HALF_PERIOD - 1));
        rise_tick = wrap && !sspclkout;
        cnt_d     = wrap ? '0 : cnt + CNT_W'(1);
        sclk_d    = wrap ? ~sspclkout : sspclkout;
    end

    always_comb begin
        state_d  = state;
        shreg_d  = shreg;
        bitcnt_d = bitcnt;
        txd_d    = ssptxd;
        fss_d    = sspfssout;
        oe_b_d   = sspoe_b;
        t_en_d   = 1'b0;

        case (state)
            IDLE: begin
                // t_en is registered: the request is seen one cycle, the word is
                // taken in the following t_en cycle while the FIFO head is valid.
                if (t_en) begin
                    shreg_d = txdata;
                    state_d = ARM;
                end else if (sse && !tx_empty) begin
                    t_en_d = 1'b1;
                end
            end
            ARM: begin
                if (rise_tick) begin
                    fss_d   = 1'b1;
                    oe_b_d  = 1'b0;
                    txd_d   = 1'b0;
                    state_d = FSS;
                end
            end
            FSS: begin
                if (rise_tick) begin
                    fss_d    = 1'b0;
                    txd_d    = shreg[DATA_W-1];
                    shreg_d  = {shreg[DATA_W-2:0], 1'b0};
                    bitcnt_d = BIT_W'(DATA_W - 1);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (rise_tick) begin
                    if (bitcnt != '0) begin
                        txd_d    = shreg[DATA_W-1];
                        shreg_d  = {shreg[DATA_W-2:0], 1'b0};
                        bitcnt_d = bitcnt - BIT_W'(1);
                    end else begin
                        txd_d   = 1'b0;
                        oe_b_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_busy = (state != IDLE);

endmodule
